// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller: optional dirty-victim writeback, four-beat line fetch, one-cycle fill strobe.
// Define REFILL_PERF_CNT_EN to build the saturating refill/writeback counters.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_req,
  output logic                     miss_ready,
  input  logic [ADDR_WIDTH-1:0]    miss_addr,
  input  logic                     victim_dirty,
  input  logic [ADDR_WIDTH-1:0]    victim_addr,
  input  logic [LINE_WORDS*32-1:0] victim_line,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     fill_valid,
  output logic [ADDR_WIDTH-1:0]    fill_addr,
  output logic [LINE_WORDS*32-1:0] fill_line,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     refill_count,
  output logic [CNT_WIDTH-1:0]     wb_count
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam int LW  = LINE_WORDS * 32;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FILL    = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:OFF]  tag_q, tag_d;
  logic [ADDR_WIDTH-1:OFF]  vtag_q, vtag_d;
  logic [LW-1:0]            vline_q, vline_d;
  logic [LW-1:0]            line_q, line_d;

  // Only line-aligned addresses are kept; the offset bits never reach a register.
  logic unused_lsb;
  assign unused_lsb = ^{miss_addr[OFF-1:0], victim_addr[OFF-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      vline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tag_q   <= tag_d;
      vtag_q  <= vtag_d;
      vline_q <= vline_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tag_d   = tag_q;
    vtag_d  = vtag_q;
    vline_d = vline_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          tag_d   = miss_addr[ADDR_WIDTH-1:OFF];
          vtag_d  = victim_addr[ADDR_WIDTH-1:OFF];
          vline_d = victim_line;
          beat_d  = '0;
          state_d = victim_dirty ? S_WB : S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            beat_d  = beat_q + BW'(1);
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_RD_REQ: begin
        if (mem_ready) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        // Data can only arrive here, so a response seen in RD_REQ is dropped.
        if (mem_rvalid) begin
          line_d[{beat_q, 5'b00000} +: 32] = mem_rdata;
          beat_d  = beat_q + BW'(1);
          state_d = (beat_q == LAST_BEAT) ? S_FILL : S_RD_REQ;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; forced low while reset is asserted.
  always_comb begin
    miss_ready = 1'b0;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'h0000_0000;
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_line  = '0;
    if (reset) begin
      busy = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: miss_ready = 1'b1;
        S_WB: begin
          busy      = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {vtag_q, beat_q, 2'b00};
          mem_wdata = vline_q[{beat_q, 5'b00000} +: 32];
        end
        S_RD_REQ: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {tag_q, beat_q, 2'b00};
        end
        S_RD_WAIT: busy = 1'b1;
        S_FILL: begin
          busy       = 1'b1;
          fill_valid = 1'b1;
          fill_addr  = {tag_q, {OFF{1'b0}}};
          fill_line  = line_q;
        end
        default: busy = 1'b0;
      endcase
    end
  end

`ifdef REFILL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] refill_cnt_q;
  logic [CNT_WIDTH-1:0] wb_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      refill_cnt_q <= '0;
      wb_cnt_q     <= '0;
    end else begin
      if (state_q == S_FILL && refill_cnt_q != {CNT_WIDTH{1'b1}}) begin
        refill_cnt_q <= refill_cnt_q + CNT_WIDTH'(1);
      end
      if (state_q == S_WB && mem_ready && beat_q == LAST_BEAT &&
          wb_cnt_q != {CNT_WIDTH{1'b1}}) begin
        wb_cnt_q <= wb_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign refill_count = reset ? '0 : refill_cnt_q;
  assign wb_count     = reset ? '0 : wb_cnt_q;
`else
  assign refill_count = '0;
  assign wb_count     = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a reactive memory model plus queues of expected beats and fills.
module tb_cache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         miss_req;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         victim_dirty;
  logic [31:0]  victim_addr;
  logic [127:0] victim_line;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;
  logic         busy;
  logic [1:0]   refill_count;
  logic [1:0]   wb_count;

  cache_refill_ctrl #(.ADDR_WIDTH(32), .LINE_WORDS(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
    .busy(busy), .refill_count(refill_count), .wb_count(wb_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          last_wb;
  } beat_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
    int           lat;
  } fill_t;

  beat_t       exp_beats[$];
  fill_t       exp_fills[$];
  int          acc_q[$];
  logic [31:0] rd_words[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_beats = 0;
  int n_fill = 0;
  int n_fill_exp = 0;
  int exp_refill = 0;
  int exp_wb = 0;
  int cyc = 0;

  // memory-model knobs (global read-beat indices, -1 = off)
  int rd_acc = 0;
  int stall_at = -1;
  int stall_n = 0;
  int rvd_at = -1;
  int rvd_n = 0;
  int spur_at = -1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reactive memory: acknowledges beats, returns read data, injects stalls and a stray response.
  initial begin
    bit accept_next;
    bit rv_armed;
    int rv_wait;
    int stall_left;
    accept_next = 1'b0;
    rv_armed    = 1'b0;
    rv_wait     = 0;
    stall_left  = 0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        accept_next = 1'b0;
        rv_armed    = 1'b0;
        stall_left  = 0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
      end else begin
        if (accept_next) begin
          rv_armed    = 1'b1;
          rv_wait     = ((rd_acc - 1) == rvd_at) ? rvd_n : 0;
          if ((rd_acc - 1) == rvd_at) rvd_at = -1;
          accept_next = 1'b0;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (rv_armed) begin
          if (rv_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rd_words.size() > 0) ? rd_words.pop_front() : 32'h0;
            rv_armed   = 1'b0;
          end else begin
            rv_wait--;
          end
        end
        mem_ready = 1'b0;
        if (mem_req) begin
          if (!mem_we && rd_acc == stall_at) begin
            stall_left = stall_n;
            stall_at   = -1;
          end
          if (stall_left > 0) stall_left--;
          else mem_ready = 1'b1;
          if (!mem_we && rd_acc == spur_at) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            spur_at    = -1;
          end
          if (mem_ready && !mem_we) begin
            accept_next = 1'b1;
            rd_acc++;
          end
        end
      end
    end
  end

  // Monitor: compares every accepted beat and every fill against the scoreboard.
  initial begin
    bit    prev_fill;
    beat_t b;
    fill_t f;
    int    a;
    prev_fill = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset) begin
        prev_fill = 1'b0;
      end else begin
        if (prev_fill) chk("ready_after_fill", miss_ready, 1);
        prev_fill = fill_valid;
        if (miss_req && miss_ready) acc_q.push_back(cyc);
        if (mem_req && mem_ready) begin
          n_beats++;
          if (exp_beats.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            b = exp_beats.pop_front();
            chk("beat_we", mem_we, b.we);
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_wdata", mem_wdata, b.wdata);
            if (b.last_wb) exp_wb++;
          end
        end else if (mem_req && exp_beats.size() > 0) begin
          chk("stall_addr", mem_addr, exp_beats[0].addr);
          chk("stall_we", mem_we, exp_beats[0].we);
        end
        if (fill_valid) begin
          n_fill++;
          exp_refill++;
          chk("fill_ready_low", miss_ready, 0);
          if (exp_fills.size() == 0) begin
            chk("extra_fill", 1, 0);
          end else begin
            f = exp_fills.pop_front();
            chk("fill_addr", fill_addr, f.addr);
            chk("fill_line", fill_line, f.line);
            if (acc_q.size() > 0) begin
              a = acc_q.pop_front();
              if (f.lat >= 0) chk("fill_latency", cyc - a, f.lat);
            end
          end
        end
      end
    end
  end

  task automatic issue_miss(input logic [31:0] maddr, input bit dirty, input logic [31:0] vaddr,
                            input logic [127:0] vline, input logic [127:0] rline, input int lat);
    beat_t b;
    fill_t f;
    bit    accepted;
    logic [31:0] base;
    base = {maddr[31:4], 4'h0};
    if (dirty) begin
      for (int i = 0; i < 4; i++) begin
        b.we = 1'b1; b.addr = {vaddr[31:4], 4'h0} + 32'(4 * i);
        b.wdata = vline[32*i +: 32]; b.last_wb = (i == 3);
        exp_beats.push_back(b);
      end
    end
    for (int i = 0; i < 4; i++) begin
      b.we = 1'b0; b.addr = base + 32'(4 * i); b.wdata = 32'h0; b.last_wb = 1'b0;
      exp_beats.push_back(b);
      rd_words.push_back(rline[32*i +: 32]);
    end
    f.addr = base; f.line = rline; f.lat = lat;
    exp_fills.push_back(f);
    n_fill_exp++;
    @(posedge clk);
    #1;
    miss_req = 1'b1; miss_addr = maddr; victim_dirty = dirty;
    victim_addr = vaddr; victim_line = vline;
    accepted = 1'b0;
    for (int k = 0; k < 300 && !accepted; k++) begin
      @(negedge clk);
      #2;
      if (miss_ready) accepted = 1'b1;
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    miss_req = 1'b0;
    miss_addr = $urandom; victim_dirty = $urandom_range(0, 1);
    victim_addr = $urandom; victim_line = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 500 && n_fill < n_fill_exp; k++) begin
      @(negedge clk);
      #2;
    end
    if (n_fill < n_fill_exp) chk("fill_timeout", n_fill, n_fill_exp);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic chk_cnt();
`ifdef REFILL_PERF_CNT_EN
    chk("refill_cnt", refill_count, sat3(exp_refill));
    chk("wb_cnt", wb_count, sat3(exp_wb));
`else
    chk("refill_cnt_tied", refill_count, 0);
    chk("wb_cnt_tied", wb_count, 0);
`endif
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int b0;
    int k;
    reset = 1'b1; miss_req = 1'b0; miss_addr = 32'h0; victim_dirty = 1'b0;
    victim_addr = 32'h0; victim_line = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fill_valid", fill_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("post_rst_ready", miss_ready, 1);
    chk("post_rst_busy", busy, 0);

    // clean miss
    issue_miss(32'h0001_2345, 1'b0, 32'h0000_4440, rnd_line(),
               {32'h44, 32'h33, 32'h22, 32'h11}, 9);
    wait_done();
    chk_cnt();

    // dirty miss
    issue_miss(32'h0004_0018, 1'b1, 32'h0000_8000,
               {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, rnd_line(), 13);
    wait_done();
    chk_cnt();

    // stalls: ready low on read beat 2, data late on read beat 3
    stall_at = rd_acc + 2; stall_n = 3;
    rvd_at = rd_acc + 3; rvd_n = 5;
    issue_miss(32'h00A0_0F08, 1'b0, 32'h0000_1230, rnd_line(), rnd_line(), -1);
    wait_done();
    chk_cnt();

    // ignore rules: stray rvalid in RD_REQ, miss_req pulsed in RD_WAIT
    spur_at = rd_acc + 1;
    issue_miss(32'h0BAD_0074, 1'b0, 32'h0000_2220, rnd_line(), rnd_line(), -1);
    b0 = n_beats;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (n_beats >= b0 + 1 && busy && !mem_req && !fill_valid) break;
    end
    miss_req = 1'b1; miss_addr = 32'h0FFF_FFF0; victim_dirty = 1'b1;
    chk("ignore_ready", miss_ready, 0);
    @(posedge clk);
    #1;
    miss_req = 1'b0;
    wait_done();
    chk_cnt();

    // reset during writeback after beat 1
    b0 = n_beats;
    issue_miss(32'h0000_5550, 1'b1, 32'h0000_9000, rnd_line(), rnd_line(), 13);
    for (k = 0; k < 100 && n_beats < b0 + 2; k++) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", miss_ready, 0);
    chk("midrst_fill", fill_valid, 0);
    repeat (2) @(posedge clk);
    exp_beats.delete(); exp_fills.delete(); acc_q.delete(); rd_words.delete();
    n_fill_exp = n_fill; exp_refill = 0; exp_wb = 0;
    #1;
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_ready_after", miss_ready, 1);
    chk("midrst_nofill", n_fill, n_fill_exp);
    chk_cnt();

    // clean miss after abort
    issue_miss(32'h0001_2345, 1'b0, 32'h0000_4440, rnd_line(),
               {32'h55, 32'h66, 32'h77, 32'h88}, 9);
    wait_done();
    chk_cnt();

    // back-to-back misses, driving the counters into saturation
    for (int i = 0; i < 4; i++) begin
      issue_miss($urandom, (i % 2 == 1), {$urandom_range(0, 32'hFFFF), 16'h0}, rnd_line(),
                 rnd_line(), (i % 2 == 1) ? 13 : 9);
    end
    wait_done();
    chk_cnt();

    repeat (5) @(negedge clk);
    chk("beats_left", exp_beats.size(), 0);
    chk("fills_left", exp_fills.size(), 0);
    chk("fill_total", n_fill, n_fill_exp);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling stage directly downstream of the direct-mapped cache.
- Accepts one miss request at a time.
- If the victim line is dirty, writes it back to main memory as single-word beats.
- Fetches the missing 128-bit line as four 32-bit read beats.
- Returns the assembled line to the cache with a one-cycle fill strobe.

Parameters:
ADDR_WIDTH, 32, byte address width for miss, victim and memory addresses
LINE_WORDS, 4, 32-bit words per cache line; the line is LINE_WORDS*32 = 128 bits
CNT_WIDTH, 16, width of the performance counters (optional feature only)

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
miss_req  input  1  cache requests a line refill
miss_ready  output  1  controller can accept a request (state IDLE)
miss_addr  input  ADDR_WIDTH  address that missed
victim_dirty  input  1  line being replaced is dirty
victim_addr  input  ADDR_WIDTH  base address of the victim line
victim_line  input  128  victim data; word i occupies bits [32i+31:32i]
mem_req  output  1  memory access request
mem_we  output  1  1 = write beat, 0 = read beat
mem_addr  output  ADDR_WIDTH  beat byte address
mem_wdata  output  32  write beat data
mem_ready  input  1  memory accepts the current request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
fill_valid  output  1  one-cycle strobe: fill_line/fill_addr valid
fill_addr  output  ADDR_WIDTH  line base address of the fill
fill_line  output  128  assembled line; word i in bits [32i+31:32i]
busy  output  1  controller is not IDLE
refill_count  output  CNT_WIDTH  completed refills (optional feature)
wb_count  output  CNT_WIDTH  completed writebacks (optional feature)

Behaviour:
- Reset: state goes to IDLE and all outputs are 0 in the cycle reset is sampled high. This includes miss_ready; it reads 1 from the first cycle after reset deasserts.
- Reset mid-operation aborts any transfer. No fill_valid is produced. The beat counter, captured addresses and line buffer are cleared.
- States:
  - IDLE: miss_ready=1 and busy=0.
  - On miss_req, capture the following and clear the beat counter:
    - line base = {miss_addr[ADDR_WIDTH-1:4], 4'b0}
    - victim_addr and victim_line
    - the victim_dirty flag
  - Next state is WB if victim_dirty=1, otherwise RD_REQ.
  - WB:
    - mem_req=1, mem_we=1.
    - mem_addr = victim base + 4*beat.
    - mem_wdata = victim word[beat].
    - A beat completes on mem_req && mem_ready.
    - After beat LINE_WORDS-1, clear the counter and go to RD_REQ.
  - RD_REQ:
    - mem_req=1, mem_we=0, mem_addr = line base + 4*beat.
    - On mem_ready, go to RD_WAIT; mem_req drops the next cycle.
  - RD_WAIT:
    - mem_req=0.
    - On mem_rvalid, store mem_rdata into word[beat] and increment beat.
    - If that was the last beat go to FILL, else go to RD_REQ.
  - FILL:
    - fill_valid=1 for exactly one cycle, with fill_addr and fill_line stable.
    - Next state is IDLE.
- Every state except IDLE has miss_ready=0 and busy=1.
- In states other than IDLE, miss_req is ignored. The cache holds miss_req until it sees miss_ready.
- mem_rvalid outside RD_WAIT is ignored. mem_rvalid in the same cycle as the RD_REQ acceptance is ignored; data is valid no earlier than the cycle after acceptance.
- mem_ready outside WB/RD_REQ is ignored.
- The beat counter is log2(LINE_WORDS) bits. Addresses add 4*beat with no carry into the tag bits.
- Latency, with mem_ready=1 and mem_rvalid one cycle after each request acceptance:
  - Clean miss: fill_valid asserts 9 cycles after the acceptance edge.
  - Dirty miss: fill_valid asserts 13 cycles after the acceptance edge.
- Back-to-back: miss_ready is 1 in the cycle after FILL. No request is accepted in the FILL cycle itself.
- mem_wdata is 0 whenever mem_we=0.

Optional Feature:
Macro REFILL_PERF_CNT_EN.
- Defined:
  - refill_count increments in every FILL cycle.
  - wb_count increments when the last WB beat completes.
  - Both counters saturate at all-ones.
  - Both counters clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Clean miss: miss_addr=0x0001_2345, victim_dirty=0, memory returns 0x11,0x22,0x33,0x44 → read addresses 0x0001_2340/44/48/4C, then fill_addr=0x0001_2340 and fill_line=0x00000044_00000033_00000022_00000011, fill_valid high 1 cycle, 9 cycles after acceptance.
- Dirty miss: victim_addr=0x0000_8000, victim_line words A,B,C,D → write beats at 0x8000/04/08/0C carrying A,B,C,D in order, then 4 reads; with REFILL_PERF_CNT_EN, wb_count=1 and refill_count=1.
- Stall: mem_ready low 3 cycles on beat 2, mem_rvalid delayed 5 cycles on beat 3 → mem_addr and mem_req held stable throughout, final line correct.
- Ignore rules: miss_req pulsed during RD_WAIT and a spurious mem_rvalid during RD_REQ → no second capture, line unchanged, miss_ready=0.
- Reset mid-WB after beat 1: all outputs 0, no fill_valid; miss_ready=1 the cycle after reset deasserts, and a new clean miss completes normally.
- Saturation (macro defined, CNT_WIDTH forced to 2): 5 refills → refill_count stays 3.
